// File: rtl/piarb_fid_dispatch.sv
// Per-packet flow-ID dispatcher in front of the PU-arbiter flow TCAM.
// Looks up each FID, enqueues hits to their owning slot, installs misses in the first free slot.
module piarb_fid_dispatch #(
    parameter int unsigned ID_NBITS        = 3,
    parameter int unsigned QUEUE_DEPTH     = 8,
    parameter int unsigned FID_NBITS       = 8,
    parameter int unsigned STALL_CNT_NBITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pkt_valid,
    input  logic [FID_NBITS-1:0]       pkt_fid,
    output logic                       pkt_ready,
    input  logic [QUEUE_DEPTH-1:0]     pu_queue_full,
    output logic                       fid_lookup_req,
    output logic [FID_NBITS-1:0]       fid_lookup_fid,
    input  logic                       fid_lookup_ack,
    input  logic [2*QUEUE_DEPTH-1:0]   fid_lookup_fid_valid,
    input  logic [2*QUEUE_DEPTH-1:0]   fid_lookup_fid_hit,
    output logic                       wr_fid_req,
    output logic [FID_NBITS-1:0]       wr_fid,
    output logic [QUEUE_DEPTH-1:0]     wr_fid_sel_id,
    output logic                       wr_fid_sel,
    output logic                       enq_req,
    output logic [ID_NBITS-1:0]        enq_qid,
    output logic                       enq_fid_sel,
    output logic [STALL_CNT_NBITS-1:0] stall_cnt,
    output logic                       err_multi_hit
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, ISSUE, RETRY} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [FID_NBITS-1:0]       r_fid;
    logic                       r_pkt_ready;
    logic                       r_lookup_req;
    logic                       r_wr_fid_req;
    logic [FID_NBITS-1:0]       r_wr_fid;
    logic [QUEUE_DEPTH-1:0]     r_wr_sel_id;
    logic                       r_wr_fid_sel;
    logic                       r_enq_req;
    logic [ID_NBITS-1:0]        r_enq_qid;
    logic                       r_enq_fid_sel;
    logic [STALL_CNT_NBITS-1:0] r_stall_cnt;
    logic                       r_err_multi;

    logic                       w_hit_found;
    logic [ID_NBITS-1:0]        w_hit_row;
    logic                       w_hit_slot;
    logic                       w_hit_full;
    logic                       w_multi;
    logic                       w_free_found;
    logic [ID_NBITS-1:0]        w_free_row;
    logic                       w_free_slot;
    logic                       w_issue;
    logic                       w_new;
    logic [ID_NBITS-1:0]        w_row;
    logic                       w_slot;
    logic                       w_decide;

    // Priority scan: lowest row first, slot0 before slot1, for both hit and free-slot search.
    always_comb begin
        w_hit_found  = 1'b0;
        w_hit_row    = '0;
        w_hit_slot   = 1'b0;
        w_hit_full   = 1'b0;
        w_multi      = 1'b0;
        w_free_found = 1'b0;
        w_free_row   = '0;
        w_free_slot  = 1'b0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (fid_lookup_fid_hit[2*i+s]) begin
                    if (w_hit_found) begin
                        w_multi = 1'b1;
                    end else begin
                        w_hit_found = 1'b1;
                        w_hit_row   = ID_NBITS'(i);
                        w_hit_slot  = (s == 1);
                        w_hit_full  = pu_queue_full[i];
                    end
                end
                if (!w_free_found && !fid_lookup_fid_valid[2*i+s] && !pu_queue_full[i]) begin
                    w_free_found = 1'b1;
                    w_free_row   = ID_NBITS'(i);
                    w_free_slot  = (s == 1);
                end
            end
        end
    end

    assign w_decide = (r_state == WAIT) && fid_lookup_ack;

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_new   = 1'b0;
        w_row   = '0;
        w_slot  = 1'b0;
        case (r_state)
            IDLE:   if (pkt_valid && r_pkt_ready) w_next = LOOKUP;
            LOOKUP: w_next = WAIT;
            WAIT: begin
                if (fid_lookup_ack) begin
                    if (w_hit_found) begin
                        w_row  = w_hit_row;
                        w_slot = w_hit_slot;
                        if (!w_hit_full) begin
                            w_next  = ISSUE;
                            w_issue = 1'b1;
                        end else begin
                            w_next = RETRY;
                        end
                    end else if (w_free_found) begin
                        w_row   = w_free_row;
                        w_slot  = w_free_slot;
                        w_next  = ISSUE;
                        w_issue = 1'b1;
                        w_new   = 1'b1;
                    end else begin
                        w_next = RETRY;
                    end
                end
            end
            ISSUE:   w_next = IDLE;
            RETRY:   w_next = LOOKUP;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered off the next state so each strobe lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_fid         <= '0;
            r_pkt_ready   <= 1'b1;
            r_lookup_req  <= 1'b0;
            r_wr_fid_req  <= 1'b0;
            r_wr_fid      <= '0;
            r_wr_sel_id   <= '0;
            r_wr_fid_sel  <= 1'b0;
            r_enq_req     <= 1'b0;
            r_enq_qid     <= '0;
            r_enq_fid_sel <= 1'b0;
            r_stall_cnt   <= '0;
            r_err_multi   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pkt_ready  <= (w_next == IDLE);
            r_lookup_req <= (w_next == LOOKUP);
            r_enq_req    <= w_issue;
            r_wr_fid_req <= w_new;
            r_err_multi  <= w_decide && w_multi;
            if (r_state == IDLE && pkt_valid && r_pkt_ready) begin
                r_fid <= pkt_fid;
            end
            if (w_issue) begin
                r_enq_qid     <= w_row;
                r_enq_fid_sel <= w_slot;
            end
            if (w_new) begin
                r_wr_fid     <= r_fid;
                r_wr_sel_id  <= QUEUE_DEPTH'(w_row);
                r_wr_fid_sel <= w_slot;
            end
            if (w_next == RETRY && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_NBITS'(1);
            end
        end
    end

    assign pkt_ready      = r_pkt_ready;
    assign fid_lookup_req = r_lookup_req;
    assign fid_lookup_fid = r_fid;
    assign wr_fid_req     = r_wr_fid_req;
    assign wr_fid         = r_wr_fid;
    assign wr_fid_sel_id  = r_wr_sel_id;
    assign wr_fid_sel     = r_wr_fid_sel;
    assign enq_req        = r_enq_req;
    assign enq_qid        = r_enq_qid;
    assign enq_fid_sel    = r_enq_fid_sel;
    assign stall_cnt      = r_stall_cnt;
    assign err_multi_hit  = r_err_multi;

endmodule

// File: tb/tb_piarb_fid_dispatch.sv
// Directed bench for piarb_fid_dispatch: hit/miss dispatch, retries, multi-hit, stall saturation, reset in WAIT.
module tb_piarb_fid_dispatch;

    localparam int unsigned QD = 8;
    localparam int unsigned ID = 3;
    localparam int unsigned FW = 8;
    localparam int unsigned SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pkt_valid = 1'b0;
    logic [FW-1:0]   pkt_fid = '0;
    logic            pkt_ready;
    logic [QD-1:0]   pu_queue_full = '0;
    logic            fid_lookup_req;
    logic [FW-1:0]   fid_lookup_fid;
    logic            fid_lookup_ack = 1'b0;
    logic [2*QD-1:0] fid_lookup_fid_valid = '0;
    logic [2*QD-1:0] fid_lookup_fid_hit = '0;
    logic            wr_fid_req;
    logic [FW-1:0]   wr_fid;
    logic [QD-1:0]   wr_fid_sel_id;
    logic            wr_fid_sel;
    logic            enq_req;
    logic [ID-1:0]   enq_qid;
    logic            enq_fid_sel;
    logic [SW-1:0]   stall_cnt;
    logic            err_multi_hit;

    int total = 0;
    int bad   = 0;

    piarb_fid_dispatch #(
        .ID_NBITS(ID),
        .QUEUE_DEPTH(QD),
        .FID_NBITS(FW),
        .STALL_CNT_NBITS(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pkt_valid(pkt_valid),
        .pkt_fid(pkt_fid),
        .pkt_ready(pkt_ready),
        .pu_queue_full(pu_queue_full),
        .fid_lookup_req(fid_lookup_req),
        .fid_lookup_fid(fid_lookup_fid),
        .fid_lookup_ack(fid_lookup_ack),
        .fid_lookup_fid_valid(fid_lookup_fid_valid),
        .fid_lookup_fid_hit(fid_lookup_fid_hit),
        .wr_fid_req(wr_fid_req),
        .wr_fid(wr_fid),
        .wr_fid_sel_id(wr_fid_sel_id),
        .wr_fid_sel(wr_fid_sel),
        .enq_req(enq_req),
        .enq_qid(enq_qid),
        .enq_fid_sel(enq_fid_sel),
        .stall_cnt(stall_cnt),
        .err_multi_hit(err_multi_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake a descriptor; returns at the negedge of the LOOKUP cycle.
    task automatic accept(input logic [FW-1:0] fid);
        pkt_valid = 1'b1;
        pkt_fid   = fid;
        @(negedge clk);
        pkt_valid = 1'b0;
        chk("lookup_req", 32'(fid_lookup_req), 32'd1);
        chk("lookup_fid", 32'(fid_lookup_fid), 32'(fid));
        chk("ready_busy", 32'(pkt_ready), 32'd0);
    endtask

    // From the LOOKUP negedge: enter WAIT, hold for 'delay' cycles, ack; returns at ISSUE/RETRY negedge.
    task automatic respond(input logic [2*QD-1:0] vld, input logic [2*QD-1:0] hit,
                           input logic [QD-1:0] full, input int delay);
        @(negedge clk);
        chk("lookup_one_cycle", 32'(fid_lookup_req), 32'd0);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("wait_no_enq", 32'(enq_req), 32'd0);
        end
        fid_lookup_ack       = 1'b1;
        fid_lookup_fid_valid = vld;
        fid_lookup_fid_hit   = hit;
        pu_queue_full        = full;
        @(negedge clk);
        fid_lookup_ack = 1'b0;
    endtask

    task automatic chk_issue(input logic wr, input logic [FW-1:0] fid, input int qid,
                             input logic sel, input logic err);
        chk("enq_req", 32'(enq_req), 32'd1);
        chk("enq_qid", 32'(enq_qid), 32'(qid));
        chk("enq_fid_sel", 32'(enq_fid_sel), 32'(sel));
        chk("wr_fid_req", 32'(wr_fid_req), 32'(wr));
        if (wr) begin
            chk("wr_fid", 32'(wr_fid), 32'(fid));
            chk("wr_fid_sel_id", 32'(wr_fid_sel_id), 32'(qid));
            chk("wr_fid_sel", 32'(wr_fid_sel), 32'(sel));
        end
        chk("err_multi_hit", 32'(err_multi_hit), 32'(err));
        @(negedge clk);
        chk("ready_again", 32'(pkt_ready), 32'd1);
        chk("enq_pulse", 32'(enq_req), 32'd0);
        chk("wr_pulse", 32'(wr_fid_req), 32'd0);
        chk("err_pulse", 32'(err_multi_hit), 32'd0);
    endtask

    task automatic chk_retry(input int stall);
        chk("retry_no_enq", 32'(enq_req), 32'd0);
        chk("retry_no_wr", 32'(wr_fid_req), 32'd0);
        chk("retry_ready", 32'(pkt_ready), 32'd0);
        chk("stall_cnt", 32'(stall_cnt), 32'(stall));
        @(negedge clk);
        chk("relookup_req", 32'(fid_lookup_req), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(pkt_ready), 32'd1);
        chk("rst_lookup", 32'(fid_lookup_req), 32'd0);
        chk("rst_wr", 32'(wr_fid_req), 32'd0);
        chk("rst_enq", 32'(enq_req), 32'd0);
        chk("rst_err", 32'(err_multi_hit), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_data", {enq_qid, enq_fid_sel, wr_fid, wr_fid_sel_id, wr_fid_sel, fid_lookup_fid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // stray ack in IDLE must be ignored
        fid_lookup_ack = 1'b1;
        @(negedge clk);
        fid_lookup_ack = 1'b0;
        chk("idle_ack_ignored", 32'({enq_req, wr_fid_req, fid_lookup_req}), 32'd0);
        chk("idle_ready", 32'(pkt_ready), 32'd1);

        // empty TCAM miss -> NEW at (0,0)
        accept(8'h12);
        respond('0, '0, '0, 0);
        chk_issue(1'b1, 8'h12, 0, 1'b0, 1'b0);

        // hit row0 slot0 -> enq only
        accept(8'h12);
        respond(16'h0001, 16'h0001, '0, 0);
        chk_issue(1'b0, 8'h12, 0, 1'b0, 1'b0);

        // rows 0-2 full occupancy, row3 slot0 used -> NEW at (3,1)
        accept(8'h34);
        respond(16'h007F, '0, '0, 0);
        chk_issue(1'b1, 8'h34, 3, 1'b1, 1'b0);

        // hit (5,1) with PU5 full for three lookups
        accept(8'h56);
        for (int k = 1; k <= 3; k++) begin
            respond(16'h0800, 16'h0800, 8'h20, 0);
            chk_retry(k);
        end
        respond(16'h0800, 16'h0800, '0, 0);
        chk("stall_hold", 32'(stall_cnt), 32'd3);
        chk_issue(1'b0, 8'h56, 5, 1'b1, 1'b0);

        // multi-hit (2,1) and (7,0) -> lowest wins, err pulse
        accept(8'h78);
        respond(16'h4020, 16'h4020, '0, 0);
        chk_issue(1'b0, 8'h78, 2, 1'b1, 1'b1);

        // late ack extends WAIT
        accept(8'h9A);
        respond(16'h0001, '0, '0, 3);
        chk_issue(1'b1, 8'h9A, 0, 1'b1, 1'b0);

        // all slots valid -> retries until stall_cnt saturates at 4'hF
        accept(8'hBC);
        for (int k = 4; k <= 17; k++) begin
            respond(16'hFFFF, '0, '0, 0);
            chk_retry((k > 15) ? 15 : k);
        end
        // all queues full with free slots -> still retry
        respond('0, '0, 8'hFF, 0);
        chk_retry(15);

        // reset during WAIT drops the packet
        @(negedge clk);
        fid_lookup_ack       = 1'b1;
        fid_lookup_fid_valid = '0;
        fid_lookup_fid_hit   = '0;
        pu_queue_full        = '0;
        rst                  = 1'b1;
        @(negedge clk);
        chk("rstw_strobes", 32'({enq_req, wr_fid_req, fid_lookup_req, err_multi_hit}), 32'd0);
        chk("rstw_ready", 32'(pkt_ready), 32'd1);
        chk("rstw_stall", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        fid_lookup_ack = 1'b0;
        chk("post_rst_strobes", 32'({enq_req, wr_fid_req, fid_lookup_req}), 32'd0);
        chk("post_rst_ready", 32'(pkt_ready), 32'd1);
        @(negedge clk);
        chk("post_rst_idle", 32'({enq_req, wr_fid_req, fid_lookup_req, pkt_ready}), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
